pipe_stage_elastic: RTL and testbench

//  Parametrised elastic pipeline stage register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_elastic.sv | 174 +++++++++++++++++
 tb/tb_pipe_stage_elastic.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic
//   Elastic pipeline stage register placed at each inter-stage boundary
//   (IF/ID, ID/EX, EX/MEM, MEM/WB). Carries a control field and a data
//   field under a valid/ready handshake. It has a synchronous flush and a
//   saturating stall counter.
//
//   Build option: define PIPE_STAGE_SKID_EN to add a skid register. With
//   the skid register, in_ready comes straight from a flop and the
//   combinational ready path across stages is broken. Without it, the
//   stage is a single register and in_ready = ~out_valid | out_ready.
//
// Parameters
//   CTRL_W  control-field width. Zeroed on flush and on bubble.
//   DATA_W  data-field width. Only RST clears it.
//   CNT_W   stall-counter width.
//
// Ports
//   CLK        in   rising-edge clock
//   RST        in   asynchronous active-low reset
//   CLR        in   synchronous flush. Takes priority over all transfers.
//   in_valid   in   upstream has a beat
//   in_ready   out  stage accepts a beat this cycle
//   in_ctrl    in   upstream control field
//   in_data    in   upstream data field
//   out_valid  out  stage holds a beat for downstream
//   out_ready  in   downstream accepts this cycle
//   out_ctrl   out  registered control. It is 0 whenever out_valid = 0.
//   out_data   out  registered data
//   occ        out  number of beats held (0..2; 2 only with skid)
//   stall_cnt  out  saturating count of cycles with out_valid & ~out_ready
module pipe_stage_elastic #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 96,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CLR,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Main register M
  logic              m_valid_reg, m_valid_next;
  logic [CTRL_W-1:0] m_ctrl_reg,  m_ctrl_next;
  logic [DATA_W-1:0] m_data_reg,  m_data_next;
  logic [CNT_W-1:0]  stall_cnt_reg, stall_cnt_next;

  logic in_fire;
  logic out_fire;

  assign out_fire  = m_valid_reg & out_ready;
  assign in_fire   = in_valid & in_ready;
  assign out_valid = m_valid_reg;
  assign out_ctrl  = m_ctrl_reg;
  assign out_data  = m_data_reg;
  assign stall_cnt = stall_cnt_reg;

  // The stall counter saturates and ignores CLR.
  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (m_valid_reg && !out_ready && (stall_cnt_reg != CNT_MAX))
      stall_cnt_next = stall_cnt_reg + CNT_ONE;
  end

`ifdef PIPE_STAGE_SKID_EN
  // Skid register S. It catches the beat that was accepted while M was
  // stalled, because in_ready was already registered high.
  logic              s_valid_reg, s_valid_next;
  logic [CTRL_W-1:0] s_ctrl_reg,  s_ctrl_next;
  logic [DATA_W-1:0] s_data_reg,  s_data_next;

  assign in_ready = ~s_valid_reg;
  assign occ      = {1'b0, m_valid_reg} + {1'b0, s_valid_reg};

  always_comb begin
    m_valid_next = m_valid_reg;
    m_ctrl_next  = m_ctrl_reg;
    m_data_next  = m_data_reg;
    s_valid_next = s_valid_reg;
    s_ctrl_next  = s_ctrl_reg;
    s_data_next  = s_data_reg;
    if (CLR) begin
      // Drop everything except the data payloads.
      m_valid_next = 1'b0;
      m_ctrl_next  = '0;
      s_valid_next = 1'b0;
      s_ctrl_next  = '0;
    end else if (s_valid_reg) begin
      // in_ready is low here, so the only move is S -> M on drain.
      if (out_fire) begin
        m_valid_next = 1'b1;
        m_ctrl_next  = s_ctrl_reg;
        m_data_next  = s_data_reg;
        s_valid_next = 1'b0;
        s_ctrl_next  = '0;
      end
    end else if (in_fire) begin
      if (!m_valid_reg || out_fire) begin
        m_valid_next = 1'b1;
        m_ctrl_next  = in_ctrl;
        m_data_next  = in_data;
      end else begin
        s_valid_next = 1'b1;
        s_ctrl_next  = in_ctrl;
        s_data_next  = in_data;
      end
    end else if (out_fire) begin
      // Bubble: control is cleared and data is kept.
      m_valid_next = 1'b0;
      m_ctrl_next  = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s_valid_reg <= 1'b0;
      s_ctrl_reg  <= '0;
      s_data_reg  <= '0;
    end else begin
      s_valid_reg <= s_valid_next;
      s_ctrl_reg  <= s_ctrl_next;
      s_data_reg  <= s_data_next;
    end
  end
`else
  // Single register. Ready passes combinationally through the stage.
  assign in_ready = ~m_valid_reg | out_ready;
  assign occ      = {1'b0, m_valid_reg};

  always_comb begin
    m_valid_next = m_valid_reg;
    m_ctrl_next  = m_ctrl_reg;
    m_data_next  = m_data_reg;
    if (CLR) begin
      m_valid_next = 1'b0;
      m_ctrl_next  = '0;
    end else if (in_fire) begin
      m_valid_next = 1'b1;
      m_ctrl_next  = in_ctrl;
      m_data_next  = in_data;
    end else if (out_fire) begin
      m_valid_next = 1'b0;
      m_ctrl_next  = '0;
    end
  end
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_valid_reg   <= 1'b0;
      m_ctrl_reg    <= '0;
      m_data_reg    <= '0;
      stall_cnt_reg <= '0;
    end else begin
      m_valid_reg   <= m_valid_next;
      m_ctrl_reg    <= m_ctrl_next;
      m_data_reg    <= m_data_next;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic
//   Directed bench for pipe_stage_elastic (CTRL_W=8, DATA_W=96, CNT_W=3).
//   Each scenario task drives its own stimulus and checks its own results.
module tb_pipe_stage_elastic;

  localparam int CTRL_W = 8;
  localparam int DATA_W = 96;
  localparam int CNT_W  = 3;

  logic              CLK;
  logic              RST;
  logic              CLR;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occ;
  logic [CNT_W-1:0]  stall_cnt;

  int errors = 0;
  int checks = 0;

  pipe_stage_elastic #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .CLR(CLR),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occ(occ), .stall_cnt(stall_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one cycle and settle 1 ns after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_reset();
    RST = 1'b0;
    #1;
    RST = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b0; CLR = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_init out_valid got=%0b exp=0", out_valid); end
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL rst_init occ got=%0d exp=0", occ); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_init in_ready got=%0b exp=1", in_ready); end
    checks++; if (stall_cnt !== 3'd0) begin errors++; $display("FAIL rst_init stall_cnt got=%0d exp=0", stall_cnt); end
    checks++; if (out_data !== 96'h0) begin errors++; $display("FAIL rst_init out_data got=%0h exp=0", out_data); end
    RST = 1'b1;
    tick();
    // Load one beat and hold it.
    in_valid = 1'b1; in_ctrl = 8'h5A; in_data = 96'h77;
    tick();
    in_valid = 1'b0;
    checks++; if (occ !== 2'd1 || out_data !== 96'h77) begin errors++; $display("FAIL rst_load occ=%0d data=%0h exp occ=1 data=77", occ, out_data); end
    // Assert reset asynchronously in mid-cycle.
    #2 RST = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_ctrl !== 8'h00) begin errors++; $display("FAIL rst_mid out_ctrl got=%0h exp=0", out_ctrl); end
    checks++; if (out_data !== 96'h0) begin errors++; $display("FAIL rst_mid out_data got=%0h exp=0", out_data); end
    checks++; if (occ !== 2'd0) begin errors++; $display("FAIL rst_mid occ got=%0d exp=0", occ); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid in_ready got=%0b exp=1", in_ready); end
    RST = 1'b1;
    tick();
    $display("test_reset done: errors=%0d", errors);
  endtask

  task automatic test_stream();
    logic [7:0]  exp_c [3] = '{8'h01, 8'h02, 8'h03};
    logic [95:0] exp_d [3] = '{96'h11, 96'h22, 96'h33};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_ctrl = exp_c[i]; in_data = exp_d[i];
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready beat=%0d got=%0b exp=1", i, in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_ctrl !== exp_c[i] || out_data !== exp_d[i]) begin
        errors++;
        $display("FAIL stream_beat%0d valid=%0b ctrl=%0h data=%0h exp valid=1 ctrl=%0h data=%0h",
                 i, out_valid, out_ctrl, out_data, exp_c[i], exp_d[i]);
      end
      $display("stream beat %0d ctrl=%0h data=%0h", i, out_ctrl, out_data);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || out_data !== 96'h33 || occ !== 2'd0) begin
      errors++;
      $display("FAIL stream_bubble valid=%0b ctrl=%0h data=%0h occ=%0d exp 0/0/33/0", out_valid, out_ctrl, out_data, occ);
    end
  endtask

`ifndef PIPE_STAGE_SKID_EN
  task automatic test_backpressure();
    pulse_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 8'h04; in_data = 96'h44;
    tick();
    in_ctrl = 8'h05; in_data = 96'h55;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got=%0b exp=0", in_ready); end
    tick();
    checks++; if (out_data !== 96'h44 || out_ctrl !== 8'h04) begin errors++; $display("FAIL bp_hold1 data=%0h ctrl=%0h exp 44/04", out_data, out_ctrl); end
    tick();
    checks++; if (out_data !== 96'h44 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold2 data=%0h valid=%0b exp 44/1", out_data, out_valid); end
    checks++; if (stall_cnt !== 3'd2) begin errors++; $display("FAIL bp_stall_cnt got=%0d exp=2", stall_cnt); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_release got=%0b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_data !== 96'h55 || out_ctrl !== 8'h05 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_next data=%0h ctrl=%0h exp 55/05", out_data, out_ctrl); end
    tick();
    checks++; if (out_valid !== 1'b0 || out_data !== 96'h55) begin errors++; $display("FAIL bp_drain valid=%0b data=%0h exp 0/55", out_valid, out_data); end
    $display("test_backpressure done: errors=%0d", errors);
  endtask
`else
  task automatic test_skid();
    pulse_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_ctrl = 8'hA1; in_data = 96'hA1;
    tick();
    in_ctrl = 8'hA2; in_data = 96'hA2; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (occ !== 2'd2) begin errors++; $display("FAIL skid_occ2 got=%0d exp=2", occ); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL skid_ready got=%0b exp=0", in_ready); end
    checks++; if (out_data !== 96'hA1 || out_ctrl !== 8'hA1) begin errors++; $display("FAIL skid_head data=%0h exp=a1", out_data); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_data !== 96'hA2 || out_ctrl !== 8'hA2 || occ !== 2'd1) begin errors++; $display("FAIL skid_second data=%0h occ=%0d exp a2/1", out_data, occ); end
    tick();
    checks++; if (occ !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL skid_empty occ=%0d valid=%0b exp 0/0", occ, out_valid); end
    $display("test_skid done: errors=%0d", errors);
  endtask
`endif

  task automatic test_flush();
    pulse_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 8'hC1; in_data = 96'hC1;
    tick();
`ifdef PIPE_STAGE_SKID_EN
    in_ctrl = 8'hC2; in_data = 96'hC2;
    tick();
    checks++; if (occ !== 2'd2) begin errors++; $display("FAIL flush_pre occ got=%0d exp=2", occ); end
`else
    // Make in_ready high so the flushed cycle carries a real in_fire.
    out_ready = 1'b1;
    checks++; if (occ !== 2'd1) begin errors++; $display("FAIL flush_pre occ got=%0d exp=1", occ); end
`endif
    CLR = 1'b1; in_valid = 1'b1; in_ctrl = 8'hB0; in_data = 96'hB0;
    tick();
    CLR = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin errors++; $display("FAIL flush_clear valid=%0b ctrl=%0h exp 0/0", out_valid, out_ctrl); end
    checks++; if (occ !== 2'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_occ occ=%0d in_ready=%0b exp 0/1", occ, in_ready); end
    checks++; if (out_data !== 96'hC1) begin errors++; $display("FAIL flush_data got=%0h exp=c1", out_data); end
    tick(); tick();
    checks++; if (out_valid !== 1'b0 || out_data === 96'hB0) begin errors++; $display("FAIL flush_discard valid=%0b data=%0h exp valid=0 data!=b0", out_valid, out_data); end
    $display("test_flush done: errors=%0d", errors);
  endtask

  task automatic test_stall_sat();
    pulse_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 8'h06; in_data = 96'h66;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    checks++; if (stall_cnt !== 3'd3) begin errors++; $display("FAIL stall_mid got=%0d exp=3", stall_cnt); end
    repeat (7) tick();
    checks++; if (stall_cnt !== 3'd7) begin errors++; $display("FAIL stall_sat got=%0d exp=7", stall_cnt); end
    repeat (2) tick();
    checks++; if (stall_cnt !== 3'd7) begin errors++; $display("FAIL stall_hold got=%0d exp=7", stall_cnt); end
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    tick();
    checks++; if (stall_cnt !== 3'd7 || out_valid !== 1'b0) begin errors++; $display("FAIL stall_clr cnt=%0d valid=%0b exp 7/0", stall_cnt, out_valid); end
    $display("test_stall_sat done: errors=%0d", errors);
  endtask

  initial begin
    test_reset();
    test_stream();
`ifndef PIPE_STAGE_SKID_EN
    test_backpressure();
`else
    test_skid();
`endif
    test_flush();
    test_stall_sat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
